// File: rtl/prco_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
interface prco_fetch_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              q_mem_req;
    logic [ADDR_W-1:0] q_mem_addr;
    logic              i_mem_ack;
    logic [15:0]       i_mem_data;

    modport master (
        output q_mem_req,
        output q_mem_addr,
        input  i_mem_ack,
        input  i_mem_data
    );

    modport slave (
        input  q_mem_req,
        input  q_mem_addr,
        output i_mem_ack,
        output i_mem_data
    );
endinterface

// File: rtl/prco_fetch.sv
// PRCO instruction fetch: PC, single-outstanding req/ack memory fetch, small in-order
// instruction buffer feeding the decoder, with stall and flushing jump redirect.
module prco_fetch #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stall,
    input  logic              i_jmp_en,
    input  logic [ADDR_W-1:0] i_jmp_addr,
    prco_fetch_if.master      io_mem,
    output logic [15:0]       q_instr,
    output logic [ADDR_W-1:0] q_instr_pc,
    output logic              q_valid
);
    localparam int unsigned     CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    typedef struct packed {
        logic [15:0]       instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nx;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_drop_addr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_pop;
    logic              w_pop;
    logic              w_push;
    entry_t            w_new;
    entry_t            r_fifo    [DEPTH];
    entry_t            w_fifo_nx [DEPTH];

    // A jump flushes everything, so it suppresses both the pop and the push of its cycle.
    assign w_pop       = q_valid && !i_stall && !i_jmp_en;
    assign w_push      = (r_state == S_REQ) && io_mem.i_mem_ack && !i_jmp_en;
    assign w_count_pop = r_count - CNT_W'(w_pop);
    assign w_new       = '{instr: io_mem.i_mem_data, pc: r_pc};

    always_comb begin
        // NOTE: assigning the default before the case keeps this block free of inferred latches.
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_jmp_en || (w_count_pop < DEPTH_C)) w_state_nx = S_REQ;
            end
            S_REQ: begin
                if (i_jmp_en)
                    w_state_nx = io_mem.i_mem_ack ? S_REQ : S_DROP;
                else if (io_mem.i_mem_ack)
                    w_state_nx = ((w_count_pop + 1'b1) < DEPTH_C) ? S_REQ : S_IDLE;
            end
            S_DROP: begin
                if (io_mem.i_mem_ack) w_state_nx = S_REQ;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_drop_addr <= RESET_PC;
            r_count     <= '0;
        end else begin
            r_state <= w_state_nx;
            if (i_jmp_en)
                r_pc <= i_jmp_addr;
            else if (w_push)
                r_pc <= r_pc + 1'b1;
            // The abandoned address stays on the bus until memory finishes that handshake.
            if ((r_state == S_REQ) && (w_state_nx == S_DROP))
                r_drop_addr <= r_pc;
            r_count <= i_jmp_en ? '0 : (w_count_pop + CNT_W'(w_push));
        end
    end

    // Slot 0 is the head; a pop shifts live entries down and a push lands just above them.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        localparam logic [CNT_W-1:0] SLOT = CNT_W'(g);
        assign w_fifo_nx[g] = (w_push && (w_count_pop == SLOT))   ? w_new                    :
                              (w_pop && ((SLOT + 1'b1) < r_count)) ? r_fifo[(g + 1) % DEPTH] :
                                                                     r_fifo[g];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            // NOTE: the whole buffer is reset, not only the head, so the head outputs read 0
            // out of reset and no unknown entry can ever shift into the head.
            r_fifo <= '{default: '0};
        end else begin
            r_fifo <= w_fifo_nx;
        end
    end

    assign q_instr           = r_fifo[0].instr;
    assign q_instr_pc        = r_fifo[0].pc;
    assign q_valid           = (r_count != '0);
    assign io_mem.q_mem_req  = (r_state != S_IDLE);
    assign io_mem.q_mem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;
endmodule

// File: tb/tb_prco_fetch.sv
// Self-checking bench for prco_fetch: memory model with selectable latency, a queue of
// expected instruction addresses rebuilt on reset/jump, and a monitor popping it on each issue.
module tb_prco_fetch;
    localparam int unsigned ADDR_W   = 8;
    localparam logic [7:0]  RESET_PC = 8'h00;
    localparam int unsigned DEPTH    = 2;

    logic        i_clk   = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_jmp_en = 1'b0;
    logic [7:0]  i_jmp_addr = 8'h00;
    logic [15:0] q_instr;
    logic [7:0]  q_instr_pc;
    logic        q_valid;

    prco_fetch_if #(.ADDR_W(ADDR_W)) mif ();

    prco_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_stall    (i_stall),
        .i_jmp_en   (i_jmp_en),
        .i_jmp_addr (i_jmp_addr),
        .io_mem     (mif),
        .q_instr    (q_instr),
        .q_instr_pc (q_instr_pc),
        .q_valid    (q_valid)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return 16'h1000 + {8'h00, a};
    endfunction

    // ---------------- memory model ----------------
    int         lat_mode    = 0;   // <0: random 0..3 wait cycles per request
    bit         spurious_en = 1'b0;
    bit         req_active  = 1'b0;
    int         wait_cnt    = 0;
    int         lat         = 0;
    logic [7:0] req_addr    = 8'h00;

    initial begin
        mif.i_mem_ack  = 1'b0;
        mif.i_mem_data = 16'h0000;
        forever begin
            @(posedge i_clk);
            #2;
            if (i_reset) begin
                mif.i_mem_ack = 1'b0;
                req_active    = 1'b0;
            end else if (mif.q_mem_req) begin
                if (!req_active) begin
                    req_active = 1'b1;
                    req_addr   = mif.q_mem_addr;
                    wait_cnt   = 0;
                    lat        = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
                end else begin
                    check("addr_stable", {24'h0, mif.q_mem_addr}, {24'h0, req_addr});
                    wait_cnt++;
                end
                if (wait_cnt >= lat) begin
                    mif.i_mem_ack  = 1'b1;
                    mif.i_mem_data = mem_word(mif.q_mem_addr);
                    req_active     = 1'b0;
                end else begin
                    mif.i_mem_ack  = 1'b0;
                    mif.i_mem_data = 16'hDEAD;
                end
            end else begin
                req_active     = 1'b0;
                mif.i_mem_ack  = spurious_en && ($urandom_range(3, 0) == 0);
                mif.i_mem_data = 16'hBA00 | 16'($urandom_range(255, 0));
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q [$];
    logic [7:0] fill_pc  = RESET_PC;
    bit         prev_jmp = 1'b0;
    int         n_pops   = 0;
    bit         seen [256];

    function automatic void top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(fill_pc);
            fill_pc = fill_pc + 8'd1;
        end
    endfunction

    function automatic void rebuild(input logic [7:0] start);
        exp_q.delete();
        fill_pc = start;
        top_up();
    endfunction

    task automatic clear_seen();
        foreach (seen[i]) seen[i] = 1'b0;
    endtask

    initial begin
        rebuild(RESET_PC);
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                rebuild(RESET_PC);
                prev_jmp = 1'b0;
            end else begin
                if (prev_jmp) check("valid_after_jmp", {31'h0, q_valid}, 32'h0);
                if (q_valid) begin
                    check("head_pc", {24'h0, q_instr_pc}, {24'h0, exp_q[0]});
                    check("head_instr", {16'h0, q_instr}, {16'h0, mem_word(exp_q[0])});
                    seen[q_instr_pc] = 1'b1;
                    if (!i_stall && !i_jmp_en) begin
                        void'(exp_q.pop_front());
                        n_pops++;
                        top_up();
                    end
                end
                if (i_jmp_en) rebuild(i_jmp_addr);
                prev_jmp = i_jmp_en;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(posedge i_clk);
        #3;
        i_reset  = 1'b1;
        i_stall  = 1'b0;
        i_jmp_en = 1'b0;
        repeat (2) @(posedge i_clk);
        #3;
        i_reset = 1'b0;
        clear_seen();
    endtask

    task automatic jump(input logic [7:0] addr);
        i_jmp_en   = 1'b1;
        i_jmp_addr = addr;
        @(posedge i_clk);
        #3;
        i_jmp_en = 1'b0;
    endtask

    // Returns at posedge+3 of a cycle with a request outstanding and no ack yet.
    task automatic wait_outstanding(input string name, input bit need_valid);
        bit found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge i_clk);
            #3;
            found = mif.q_mem_req && !mif.i_mem_ack && (q_valid || !need_valid);
        end
        check(name, {31'h0, found}, 32'h1);
    endtask

    task automatic wait_seen(input logic [7:0] pc, input int budget, input string name);
        int k = 0;
        while (!seen[pc] && k < budget) begin
            @(negedge i_clk);
            k++;
        end
        check(name, {31'h0, seen[pc]}, 32'h1);
    endtask

    initial begin
        // Asynchronous reset before any clock activity.
        #1 i_reset = 1'b1;
        #1;
        check("rst_req",  {31'h0, mif.q_mem_req}, 32'h0);
        check("rst_addr", {24'h0, mif.q_mem_addr}, {24'h0, RESET_PC});
        check("rst_valid", {31'h0, q_valid}, 32'h0);
        check("rst_instr", {16'h0, q_instr}, 32'h0);
        check("rst_pc",   {24'h0, q_instr_pc}, 32'h0);

        // Sequential fetch, 0-wait memory: one instruction per cycle from cycle 2.
        lat_mode = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            check("seq_valid", {31'h0, q_valid}, {31'h0, c >= 2});
            if (c == 1) check("seq_req", {31'h0, mif.q_mem_req}, 32'h1);
        end

        // Three-cycle memory: one instruction every third cycle.
        lat_mode = 2;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge i_clk);
            check("lat3_valid", {31'h0, q_valid}, {31'h0, (c >= 4) && ((c - 4) % 3 == 0)});
        end

        // Stall held 10 cycles: buffer fills, requests stop, then drain in order.
        lat_mode = 0;
        do_reset();
        repeat (5) @(posedge i_clk);
        #3 i_stall = 1'b1;
        repeat (10) @(negedge i_clk);
        check("stall_req_off", {31'h0, mif.q_mem_req}, 32'h0);
        check("stall_valid",   {31'h0, q_valid}, 32'h1);
        @(posedge i_clk);
        #3 i_stall = 1'b0;
        @(negedge i_clk);
        check("release_valid", {31'h0, q_valid}, 32'h1);
        @(negedge i_clk);
        check("resume_req", {31'h0, mif.q_mem_req}, 32'h1);
        repeat (6) @(negedge i_clk);

        // Jump while a slow request is outstanding: its data must be dropped.
        lat_mode = 3;
        do_reset();
        wait_outstanding("jmp_out_setup", 1'b0);
        jump(8'h40);
        wait_seen(8'h41, 40, "jmp_out_reach");

        // Jump coinciding with ack and pop at full 0-wait throughput.
        lat_mode = 0;
        do_reset();
        repeat (6) @(posedge i_clk);
        #3;
        jump(8'h20);
        @(negedge i_clk);
        @(negedge i_clk);
        check("jmp_ack_latency", {31'h0, q_valid}, 32'h1);
        wait_seen(8'h23, 20, "jmp_ack_reach");

        // Two jumps while the abandoned request is still pending: the last target wins.
        lat_mode = 3;
        do_reset();
        wait_outstanding("drop_setup", 1'b0);
        jump(8'h80);
        jump(8'h90);
        wait_seen(8'h91, 40, "drop_reach");
        check("drop_no_first_target", {31'h0, seen[8'h80]}, 32'h0);

        // PC wraps from FF to 00.
        lat_mode = 0;
        clear_seen();
        @(posedge i_clk);
        #3;
        jump(8'hFE);
        wait_seen(8'h01, 20, "wrap_reach");

        // Asynchronous reset in the middle of a request with a non-empty buffer.
        lat_mode = 3;
        do_reset();
        i_stall = 1'b1;
        wait_outstanding("midreq_setup", 1'b1);
        i_reset = 1'b1;
        #1;
        check("midreq_req",   {31'h0, mif.q_mem_req}, 32'h0);
        check("midreq_valid", {31'h0, q_valid}, 32'h0);
        check("midreq_addr",  {24'h0, mif.q_mem_addr}, {24'h0, RESET_PC});
        repeat (2) @(posedge i_clk);
        #3;
        i_stall = 1'b0;
        i_reset = 1'b0;
        clear_seen();
        wait_seen(RESET_PC + 8'd1, 40, "midreq_restart");

        // Randomized traffic: stalls, jumps, variable latency, stray acks.
        lat_mode    = -1;
        spurious_en = 1'b1;
        begin
            int pops_start = n_pops;
            for (int c = 0; c < 1500; c++) begin
                @(posedge i_clk);
                #3;
                i_stall    = ($urandom_range(3, 0) == 0);
                i_jmp_en   = ($urandom_range(31, 0) == 0);
                i_jmp_addr = 8'($urandom_range(255, 0));
            end
            @(posedge i_clk);
            #3;
            i_stall  = 1'b0;
            i_jmp_en = 1'b0;
            repeat (4) @(negedge i_clk);
            check("rand_progress", {31'h0, (n_pops - pops_start) > 100}, 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/prco_fetch.md
Name: prco_fetch

Overview:
Instruction fetch stage sitting directly upstream of the PRCO decoder.
- Maintains the program counter.
- Fetches 16-bit instruction words from instruction memory over a req/ack handshake.
- Buffers fetched words in a small FIFO.
- Presents one instruction per cycle to the decoder (q_valid drives the decoder enable, q_instr drives its instruction input).
- Handles downstream stall and jump redirect, with flush.

Parameters:
ADDR_W, 8, width of word-addressed PC / instruction memory address
RESET_PC, 0, PC value loaded on reset
DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
i_clk  input  1  clock, all state on rising edge
i_reset  input  1  asynchronous, active-high reset
i_stall  input  1  decoder cannot accept this cycle; head entry held
i_jmp_en  input  1  redirect request, single-cycle pulse
i_jmp_addr  input  ADDR_W  redirect target, sampled when i_jmp_en=1
q_mem_req  output  1  instruction memory request
q_mem_addr  output  ADDR_W  word address of request
i_mem_ack  input  1  memory completes current request; i_mem_data valid this cycle
i_mem_data  input  16  instruction word
q_instr  output  16  FIFO head instruction
q_instr_pc  output  ADDR_W  address of q_instr
q_valid  output  1  FIFO non-empty; q_instr/q_instr_pc meaningful

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc=RESET_PC; FIFO count=0; state=S_IDLE.
  - q_mem_req=0, q_mem_addr=RESET_PC, q_valid=0, q_instr=0, q_instr_pc=0.
  - Reset mid-handshake abandons the request; any ack arriving while reset is high is ignored.
- FIFO:
  - Entries hold {instr, pc}; outputs come from registered head storage.
  - Pop when q_valid=1 and i_stall=0.
  - Push on an accepted ack in S_REQ.
  - Push and pop in the same cycle leaves count unchanged.
  - Empty: q_valid=0, and q_instr/q_instr_pc hold their last values.
- States:
  - S_IDLE: q_mem_req=0.
    - Go to S_REQ when room exists, i.e. count-after-pop < DEPTH.
    - q_mem_addr=pc is driven from the registered pc.
  - S_REQ: q_mem_req=1; q_mem_addr=pc, held stable until ack.
    - On i_mem_ack: push {i_mem_data, pc}; pc<=pc+1 (wraps 2^ADDR_W-1 -> 0).
    - After the ack, go to S_REQ if room remains after this push/pop, else S_IDLE.
    - Back-to-back requests are allowed, so the throughput is 1 word/cycle with a 0-wait memory.
  - S_DROP: q_mem_req=1 with the abandoned address held stable (the address never changes mid-handshake).
    - On i_mem_ack the data is discarded and the state goes to S_REQ at the new pc.
- Only one request is outstanding at a time. A request is never issued while the FIFO is full, so an ack can never arrive when the FIFO is full.
- Ack latency >= 0: ack may coincide with the first cycle of q_mem_req.
- i_mem_ack while q_mem_req=0 is ignored.
- Redirect (i_jmp_en=1), highest priority, overrides i_stall and any pop/push:
  - FIFO flushed (count<=0); q_valid=0 on the next cycle.
  - pc<=i_jmp_addr.
  - If in S_REQ without ack this cycle, go to S_DROP.
  - If in S_REQ with ack this cycle, the data is discarded and the state goes to S_REQ at i_jmp_addr.
  - If in S_IDLE, go to S_REQ.
  - The first redirected instruction reaches q_valid no earlier than 2 cycles after i_jmp_en, with a 0-wait memory.
- Jump during S_DROP: the target is updated to the newest i_jmp_addr and the state stays in S_DROP.
- i_stall held indefinitely: the FIFO fills to DEPTH, then q_mem_req drops. On release the head pops and fetching resumes in the cycle after.

Test Plan:
- Sequential fetch, 0-wait memory, mem[k]=16'h1000+k, no stall:
  - q_valid high from cycle 2.
  - q_instr = 1000, 1001, 1002... each cycle, with q_instr_pc = 0, 1, 2...
- 3-cycle memory latency:
  - q_mem_addr stable while q_mem_req is high.
  - Exactly one push per ack; q_valid pulses once every 3 cycles with consecutive pcs.
- i_stall held 10 cycles:
  - q_instr is frozen on the same entry.
  - The FIFO reaches DEPTH=2 and q_mem_req=0.
  - On release, entries emerge in order with no loss or duplication.
- i_jmp_en with i_jmp_addr=8'h40 while a request is outstanding:
  - The old ack data never appears on q_instr.
  - Next q_valid shows q_instr_pc=40, 41...
- Also cover the jump coinciding with ack, the jump coinciding with a pop, and a double jump during S_DROP (final target wins).
- PC wrap, ADDR_W=8, starting at FE: q_instr_pc sequence FE, FF, 00, 01.
- Assert i_reset asynchronously mid-S_REQ:
  - q_mem_req=0 and q_valid=0 immediately.
  - After deassertion, fetch restarts from RESET_PC.
